cpu7_exu_scb: RTL and testbench
===============================

// Module: cpu7_exu_scb
// PURPOSE
//   Parametrised register scoreboard for the EXU. It tracks destination registers of
//   in-flight long-latency ops (LSU loads, MUL, later DIV), one writeback channel per unit.
//   It raises a decode-stage stall on RAW/WAW hazards against those ops.
//   It generalises the fixed single-load interlock to DEPTH entries, NSRC sources and NWB units.
// PARAMETERS
//   AW     5  register index width; NREG = 2**AW, r0 never tracked
//   DEPTH  4  max simultaneously pending long-latency writes (>=1)
//   NSRC   2  source-operand ports checked at decode
//   NWB    2  writeback/retire channels (0=LSU, 1=MUL, ...)
//   UW     1  unit-id width, >= clog2(NWB)
// PORTS
//   clk             in   1            clock
//   reset           in   1            synchronous, active-high reset
//   issue_valid_d   in   1            instruction valid at decode
//   issue_long_d    in   1            instruction is long-latency (result via wb channel)
//   issue_wen_d     in   1            instruction writes a register
//   issue_rd_d      in   AW           destination register
//   issue_unit_d    in   UW           wb channel that will retire it
//   rs_d            in   NSRC*AW      source registers, port i at [i*AW +: AW]
//   rs_use_d        in   NSRC         source i actually read
//   flush           in   1            pipeline flush (exception/redirect)
//   wb_valid        in   NWB          channel k writes back this cycle
//   wb_rd           in   NWB*AW       channel k destination, [k*AW +: AW]
//   scb_stall_d     out  1            hold decode this cycle
//   scb_full        out  1            all DEPTH entries valid
//   scb_count       out  clog2(DEPTH+1)  number of valid entries
//   scb_pending     out  2**AW        bit r set = register r has a pending write
//   scb_err_orphan  out  1            sticky: writeback matched no entry
// BEHAVIOUR
//   State: DEPTH entries {valid, rd[AW], unit[UW]}. Per entry: EMPTY -> PENDING on alloc;
//     PENDING -> EMPTY on retire or flush.
//   Reset: all entries EMPTY. scb_stall_d=0, scb_full=0, scb_count=0, scb_pending=0,
//     scb_err_orphan=0.
//   scb_stall_d is combinational from current (registered) entry state and decode inputs:
//     RAW:  any i with rs_use_d[i] && rs_d[i]!=0 && pending(rs_d[i]).
//     WAW:  issue_valid_d && issue_wen_d && issue_rd_d!=0 && pending(issue_rd_d),
//           for long and short ops alike.
//     FULL: issue_valid_d && issue_long_d && issue_wen_d && scb_full.
//     Stall is gated by issue_valid_d. Never stalls when issue_valid_d=0.
//   Same-cycle writeback does NOT clear a stall. The entry frees at the edge and the stall
//     drops the next cycle. A freed entry is not reusable in the cycle it frees.
//   Alloc: issue_valid_d && issue_long_d && issue_wen_d && issue_rd_d!=0 && !scb_stall_d
//     && !flush. The lowest-index EMPTY entry takes {rd,unit}. It is visible in scb_pending
//     from the next cycle (1-cycle latency).
//   Retire: for each k with wb_valid[k] && wb_rd[k]!=0, the entry with valid &&
//     unit==k && rd==wb_rd[k] goes EMPTY at the edge. WAW stall guarantees at most one match.
//     Several channels may retire in the same cycle. Retire and alloc may coincide.
//   Orphan: wb_valid[k] && wb_rd[k]!=0 with no matching entry sets scb_err_orphan.
//     Cleared only by reset. The writeback itself is ignored.
//   wb_valid[k] with wb_rd[k]==0 is ignored, with no error.
//   flush: all entries EMPTY at the edge, and alloc is suppressed that cycle.
//     A writeback that arrives in the same cycle as flush or after flush is treated as an
//     orphan only if it arrives after flush. In the flush cycle itself it is silently ignored.
//   scb_count, scb_full and scb_pending are registered-state decodes, updated at each edge.
//   Count arithmetic: next = count + alloc - popcount(retires). It never underflows or
//     exceeds DEPTH.
//   Reset asserted mid-operation overrides alloc, retire and flush in the same cycle.
// TESTING
//   1. Load r5 (unit0) alloc, next cycle use rs0=r5 -> scb_stall_d=1 until wb_valid[0],
//      wb_rd=5. Stall=0 the cycle after, scb_count 1->0.
//   2. DEPTH=4: alloc r1..r4 on units 0/1 -> scb_full=1. 5th long issue r6 -> stall=1.
//      One retire -> stall=0 next cycle, r6 allocs.
//   3. MUL r7 pending, short ALU op writing r7 -> WAW stall=1. Same-cycle wb_rd=7 ->
//      stall still 1 that cycle, 0 next.
//   4. Two channels retire r2 (unit0) and r3 (unit1) in the same cycle as alloc r9 ->
//      count 3->2, scb_pending bits 2,3 clear and bit 9 set.
//   5. wb_valid[1] wb_rd=12 with nothing pending -> scb_err_orphan=1, held until reset.
//      wb_rd=0 -> no error.
//   6. flush with 3 pending plus a simultaneous alloc -> count=0, pending=0. No stall on
//      rs matching the flushed regs.

Source files
------------

// File: rtl/cpu7_exu_scb.sv
// Register scoreboard: tracks pending long-latency destinations and raises a decode stall on RAW/WAW/full.
// Outputs are decodes of registered entry state; stall is combinational from that state plus decode inputs.
module cpu7_exu_scb #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int NSRC  = 2,
  parameter int NWB   = 2,
  parameter int UW    = 1,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int NREG = 2 ** AW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid_d,
  input  logic                 issue_long_d,
  input  logic                 issue_wen_d,
  input  logic [AW-1:0]        issue_rd_d,
  input  logic [UW-1:0]        issue_unit_d,
  input  logic [NSRC*AW-1:0]   rs_d,
  input  logic [NSRC-1:0]      rs_use_d,
  input  logic                 flush,
  input  logic [NWB-1:0]       wb_valid,
  input  logic [NWB*AW-1:0]    wb_rd,
  output logic                 scb_stall_d,
  output logic                 scb_full,
  output logic [CW-1:0]        scb_count,
  output logic [NREG-1:0]      scb_pending,
  output logic                 scb_err_orphan
);

  logic [DEPTH-1:0] ent_vld;
  logic [AW-1:0]    ent_rd   [DEPTH];
  logic [UW-1:0]    ent_unit [DEPTH];

  logic [NREG-1:0]  pend;
  logic [CW-1:0]    cnt;
  logic             raw_hz;
  logic             waw_hz;
  logic             full_hz;
  logic [DEPTH-1:0] ret;
  logic [NWB-1:0]   wb_act;
  logic [NWB-1:0]   wb_hit;
  logic [DEPTH-1:0] free_oh;
  logic             alloc;

  always_comb begin
    pend = '0;
    cnt  = '0;
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_vld[e]) pend[ent_rd[e]] = 1'b1;
      cnt = cnt + CW'(ent_vld[e]);
    end
  end

  assign scb_pending = pend;
  assign scb_count   = cnt;
  assign scb_full    = &ent_vld;

  always_comb begin
    raw_hz = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (rs_use_d[i] && (rs_d[i*AW +: AW] != '0) && pend[rs_d[i*AW +: AW]])
        raw_hz = 1'b1;
    end
  end

  assign waw_hz      = issue_wen_d && (issue_rd_d != '0) && pend[issue_rd_d];
  assign full_hz     = issue_long_d && issue_wen_d && scb_full;
  assign scb_stall_d = issue_valid_d && (raw_hz || waw_hz || full_hz);

  // The WAW interlock keeps at most one live entry per register, so each channel hits at most once.
  always_comb begin
    ret    = '0;
    wb_act = '0;
    wb_hit = '0;
    for (int k = 0; k < NWB; k++) begin
      wb_act[k] = wb_valid[k] && (wb_rd[k*AW +: AW] != '0);
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_act[k] && ent_vld[e] && (ent_unit[e] == UW'(k)) &&
            (ent_rd[e] == wb_rd[k*AW +: AW])) begin
          ret[e]    = 1'b1;
          wb_hit[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    free_oh = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (!ent_vld[e]) begin
        free_oh    = '0;
        free_oh[e] = 1'b1;
      end
    end
  end

  // Full already forces a stall, so a granted alloc always finds a free slot.
  assign alloc = issue_valid_d && issue_long_d && issue_wen_d && (issue_rd_d != '0) &&
                 !scb_stall_d && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld        <= '0;
      scb_err_orphan <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_rd[e]   <= '0;
        ent_unit[e] <= '0;
      end
    end else if (flush) begin
      ent_vld <= '0;
    end else begin
      ent_vld <= (ent_vld & ~ret) | (alloc ? free_oh : '0);
      for (int e = 0; e < DEPTH; e++) begin
        if (alloc && free_oh[e]) begin
          ent_rd[e]   <= issue_rd_d;
          ent_unit[e] <= issue_unit_d;
        end
      end
      if (|(wb_act & ~wb_hit)) scb_err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu7_exu_scb.sv
// Directed bench for cpu7_exu_scb: hazards, full, multi-retire, orphan, flush and mid-op reset.
module tb_cpu7_exu_scb;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid_d, issue_long_d, issue_wen_d;
  logic [4:0]  issue_rd_d;
  logic [0:0]  issue_unit_d;
  logic [9:0]  rs_d;
  logic [1:0]  rs_use_d;
  logic        flush;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic        scb_stall_d, scb_full, scb_err_orphan;
  logic [2:0]  scb_count;
  logic [31:0] scb_pending;

  int checks = 0;
  int errors = 0;

  cpu7_exu_scb dut (
    .clk(clk), .reset(reset),
    .issue_valid_d(issue_valid_d), .issue_long_d(issue_long_d), .issue_wen_d(issue_wen_d),
    .issue_rd_d(issue_rd_d), .issue_unit_d(issue_unit_d),
    .rs_d(rs_d), .rs_use_d(rs_use_d), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .scb_stall_d(scb_stall_d), .scb_full(scb_full), .scb_count(scb_count),
    .scb_pending(scb_pending), .scb_err_orphan(scb_err_orphan)
  );

  always #5 clk = ~clk;

  task automatic idle();
    issue_valid_d = 0; issue_long_d = 0; issue_wen_d = 0;
    issue_rd_d = 0; issue_unit_d = 0; rs_d = 0; rs_use_d = 0;
    flush = 0; wb_valid = 0; wb_rd = 0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic issue_long(input logic [4:0] rd, input logic u);
    issue_valid_d = 1; issue_long_d = 1; issue_wen_d = 1;
    issue_rd_d = rd; issue_unit_d = u;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    step(); reset = 1;
    step(); reset = 1; #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", scb_stall_d); end
    checks++; if (scb_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", scb_full); end
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", scb_count); end
    checks++; if (scb_pending !== 32'h0) begin errors++; $display("FAIL reset_pending: got %0h expected 0", scb_pending); end
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %0b expected 0", scb_err_orphan); end
    step(); reset = 0;
  endtask

  task automatic test_raw();
    step(); issue_long(5'd5, 1'b0); #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL raw_alloc_stall: got %0b expected 0", scb_stall_d); end
    step(); issue_valid_d = 1; rs_d = {5'd0, 5'd5}; rs_use_d = 2'b01; #1;
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL raw_stall: got %0b expected 1", scb_stall_d); end
    checks++; if (scb_count !== 3'd1) begin errors++; $display("FAIL raw_count1: got %0d expected 1", scb_count); end
    checks++; if (scb_pending !== 32'h20) begin errors++; $display("FAIL raw_pending: got %0h expected 20", scb_pending); end
    step(); rs_d = {5'd0, 5'd5}; rs_use_d = 2'b01; #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL raw_novalid: got %0b expected 0", scb_stall_d); end
    step(); issue_valid_d = 1; rs_d = {5'd5, 5'd0}; rs_use_d = 2'b10; #1;
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL raw_port1: got %0b expected 1", scb_stall_d); end
    step(); issue_valid_d = 1; rs_d = {5'd0, 5'd5}; rs_use_d = 2'b01;
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd5}; #1;
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL raw_wb_same_cycle: got %0b expected 1", scb_stall_d); end
    step(); issue_valid_d = 1; rs_d = {5'd0, 5'd5}; rs_use_d = 2'b01; #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL raw_released: got %0b expected 0", scb_stall_d); end
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL raw_count0: got %0d expected 0", scb_count); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      step(); issue_long(5'(i), 1'((i + 1) % 2)); #1;
      checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL full_fill_%0d: got %0b expected 0", i, scb_stall_d); end
    end
    step(); issue_long(5'd6, 1'b0); #1;
    checks++; if (scb_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", scb_full); end
    checks++; if (scb_count !== 3'd4) begin errors++; $display("FAIL full_count4: got %0d expected 4", scb_count); end
    checks++; if (scb_pending !== 32'h1E) begin errors++; $display("FAIL full_pending: got %0h expected 1e", scb_pending); end
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b expected 1", scb_stall_d); end
    step(); issue_long(5'd6, 1'b0); wb_valid = 2'b01; wb_rd = {5'd0, 5'd1}; #1;
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL full_wb_same_cycle: got %0b expected 1", scb_stall_d); end
    step(); issue_long(5'd6, 1'b0); #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL full_released: got %0b expected 0", scb_stall_d); end
    checks++; if (scb_count !== 3'd3) begin errors++; $display("FAIL full_count3: got %0d expected 3", scb_count); end
    step(); #1;
    checks++; if (scb_count !== 3'd4) begin errors++; $display("FAIL full_realloc_count: got %0d expected 4", scb_count); end
    checks++; if (scb_pending !== 32'h5C) begin errors++; $display("FAIL full_realloc_pending: got %0h expected 5c", scb_pending); end
    step(); wb_valid = 2'b11; wb_rd = {5'd2, 5'd3};
    step(); wb_valid = 2'b11; wb_rd = {5'd4, 5'd6};
    step(); #1;
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL full_drain: got %0d expected 0", scb_count); end
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL full_no_orphan: got %0b expected 0", scb_err_orphan); end
  endtask

  task automatic test_waw();
    step(); issue_long(5'd7, 1'b1);
    step(); issue_valid_d = 1; issue_wen_d = 1; issue_rd_d = 5'd7; #1;
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b expected 1", scb_stall_d); end
    checks++; if (scb_pending !== 32'h80) begin errors++; $display("FAIL waw_pending: got %0h expected 80", scb_pending); end
    step(); issue_valid_d = 1; issue_wen_d = 1; issue_rd_d = 5'd7;
    wb_valid = 2'b10; wb_rd = {5'd7, 5'd0}; #1;
    checks++; if (scb_stall_d !== 1'b1) begin errors++; $display("FAIL waw_wb_same_cycle: got %0b expected 1", scb_stall_d); end
    step(); issue_valid_d = 1; issue_wen_d = 1; issue_rd_d = 5'd7; #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL waw_released: got %0b expected 0", scb_stall_d); end
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL waw_count: got %0d expected 0", scb_count); end
  endtask

  task automatic test_multi_retire();
    step(); issue_long(5'd2, 1'b0);
    step(); issue_long(5'd3, 1'b1);
    step(); issue_long(5'd5, 1'b0);
    step(); issue_long(5'd9, 1'b1); wb_valid = 2'b11; wb_rd = {5'd3, 5'd2}; #1;
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL mr_stall: got %0b expected 0", scb_stall_d); end
    checks++; if (scb_count !== 3'd3) begin errors++; $display("FAIL mr_count3: got %0d expected 3", scb_count); end
    step(); #1;
    checks++; if (scb_count !== 3'd2) begin errors++; $display("FAIL mr_count2: got %0d expected 2", scb_count); end
    checks++; if (scb_pending !== 32'h220) begin errors++; $display("FAIL mr_pending: got %0h expected 220", scb_pending); end
    step(); wb_valid = 2'b11; wb_rd = {5'd9, 5'd5};
    step(); #1;
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL mr_drain: got %0d expected 0", scb_count); end
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL mr_no_orphan: got %0b expected 0", scb_err_orphan); end
  endtask

  task automatic test_orphan();
    step(); wb_valid = 2'b10; wb_rd = 10'd0; issue_long(5'd0, 1'b0);
    step(); #1;
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL orph_r0: got %0b expected 0", scb_err_orphan); end
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL orph_r0_alloc: got %0d expected 0", scb_count); end
    wb_valid = 2'b10; wb_rd = {5'd12, 5'd0};
    step(); #1;
    checks++; if (scb_err_orphan !== 1'b1) begin errors++; $display("FAIL orph_set: got %0b expected 1", scb_err_orphan); end
    step(); step(); #1;
    checks++; if (scb_err_orphan !== 1'b1) begin errors++; $display("FAIL orph_sticky: got %0b expected 1", scb_err_orphan); end
    step(); reset = 1;
    step(); reset = 0; #1;
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL orph_reset: got %0b expected 0", scb_err_orphan); end
    issue_long(5'd8, 1'b0);
    step(); wb_valid = 2'b10; wb_rd = {5'd8, 5'd0};
    step(); #1;
    checks++; if (scb_err_orphan !== 1'b1) begin errors++; $display("FAIL orph_wrong_unit: got %0b expected 1", scb_err_orphan); end
    checks++; if (scb_count !== 3'd1) begin errors++; $display("FAIL orph_ignored: got %0d expected 1", scb_count); end
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd8};
    step(); #1;
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL orph_retire: got %0d expected 0", scb_count); end
    reset = 1;
    step(); reset = 0;
  endtask

  task automatic test_flush();
    step(); issue_long(5'd1, 1'b0);
    step(); issue_long(5'd2, 1'b1);
    step(); issue_long(5'd3, 1'b0);
    step(); flush = 1; issue_long(5'd10, 1'b0); wb_valid = 2'b01; wb_rd = {5'd0, 5'd1}; #1;
    checks++; if (scb_count !== 3'd3) begin errors++; $display("FAIL fl_count3: got %0d expected 3", scb_count); end
    step(); issue_valid_d = 1; rs_d = {5'd2, 5'd1}; rs_use_d = 2'b11; #1;
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL fl_count0: got %0d expected 0", scb_count); end
    checks++; if (scb_pending !== 32'h0) begin errors++; $display("FAIL fl_pending: got %0h expected 0", scb_pending); end
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL fl_wb_ignored: got %0b expected 0", scb_err_orphan); end
    checks++; if (scb_stall_d !== 1'b0) begin errors++; $display("FAIL fl_no_stall: got %0b expected 0", scb_stall_d); end
    step(); wb_valid = 2'b10; wb_rd = {5'd2, 5'd0};
    step(); #1;
    checks++; if (scb_err_orphan !== 1'b1) begin errors++; $display("FAIL fl_post_orphan: got %0b expected 1", scb_err_orphan); end
    reset = 1;
    step(); reset = 0;
  endtask

  task automatic test_mid_reset();
    step(); issue_long(5'd4, 1'b0);
    step(); reset = 1; issue_long(5'd11, 1'b0); wb_valid = 2'b10; wb_rd = {5'd4, 5'd0};
    step(); reset = 0; #1;
    checks++; if (scb_count !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", scb_count); end
    checks++; if (scb_pending !== 32'h0) begin errors++; $display("FAIL mrst_pending: got %0h expected 0", scb_pending); end
    checks++; if (scb_err_orphan !== 1'b0) begin errors++; $display("FAIL mrst_orphan: got %0b expected 0", scb_err_orphan); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_full();
    test_waw();
    test_multi_retire();
    test_orphan();
    test_flush();
    test_mid_reset();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
